// File: rtl/fmul_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fmul_share_arb_pkg
// Brief   : Shared types and defaults for the FP32 multiplier share arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package fmul_share_arb_pkg;

  // IEEE-754 single precision word width
  localparam int FP32_W    = 32;

  // Default number of requesters and multiplier pipe depth
  localparam int DEF_N_REQ = 4;
  localparam int DEF_L_MUL = 3;

  // Exception flags returned with every result, MSB first: {ovf,unf,inv}
  typedef struct packed {
    logic ovf;
    logic unf;
    logic inv;
  } flags_t;

  // Width of a requester index; a single requester still needs one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmul_share_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin grant. The search starts at ptr and the
//           first asserted request wins; en=0 suppresses every grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fmul_share_arb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Rotating priority search starting at ptr, wrapping modulo N
  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] j_idx;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) begin
          j = j - N;
        end
        j_idx = IW'(j);
        if (!found && req[j_idx]) begin
          grant[j_idx] = 1'b1;
          idx          = j_idx;
          found        = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fmul_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : fmul_share_arb
// Brief   : Shares one external pipelined FP32 multiplier among N_REQ
//           requesters. Grants are round-robin; a tag pipe matching the
//           multiplier latency routes each result back to its requester.
// Revision: 1.0 - initial release
// ============================================================================
module fmul_share_arb
  import fmul_share_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int L_MUL = DEF_L_MUL
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][FP32_W-1:0]  req_op_a,
  input  logic [N_REQ-1:0][FP32_W-1:0]  req_op_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          mul_valid_in,
  output logic [FP32_W-1:0]             mul_op_a,
  output logic [FP32_W-1:0]             mul_op_b,
  input  logic                          mul_valid_out,
  input  logic [FP32_W-1:0]             mul_res,
  input  logic                          mul_ovf,
  input  logic                          mul_unf,
  input  logic                          mul_inv,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [FP32_W-1:0]             rsp_res,
  output flags_t                        rsp_flags,
  output logic [$clog2(L_MUL+1)-1:0]    o_in_flight,
  output logic                          o_idle,
  output logic                          o_err
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(L_MUL + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  logic [IW-1:0]   rr_ptr;
  logic            arb_en;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]   gnt_idx;
  logic            issue;

  // Tag pipe: one {valid, requester} entry per multiplier stage
  logic            tag_v   [L_MUL];
  logic [IW-1:0]   tag_idx [L_MUL];
  logic            last_v;
  logic [IW-1:0]   last_idx;

  logic [CW-1:0]   in_flight;
  logic            err;

  // Reset also gates the grant so nothing is offered while rst_n is low
  assign arb_en = i_en & rst_n;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready    = grant;
  assign issue        = |(grant & req_valid);
  assign mul_valid_in = issue;

  // AND-OR operand mux: zero when nothing is granted
  always_comb begin
    mul_op_a = '0;
    mul_op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        mul_op_a = mul_op_a | req_op_a[i];
        mul_op_b = mul_op_b | req_op_b[i];
      end
    end
  end

  // Round-robin pointer moves just past the requester that transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag pipe advances every cycle, mirroring the multiplier stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < L_MUL; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      tag_v[0]   <= issue;
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s < L_MUL; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  assign last_v   = tag_v[L_MUL-1];
  assign last_idx = tag_idx[L_MUL-1];

  // Route the returning result to the requester named by the last tag
  always_comb begin
    rsp_valid = '0;
    rsp_res   = '0;
    rsp_flags = '0;
    if (last_v) begin
      rsp_valid[last_idx] = 1'b1;
      rsp_res             = mul_res;
      rsp_flags.ovf       = mul_ovf;
      rsp_flags.unf       = mul_unf;
      rsp_flags.inv       = mul_inv;
    end
  end

  // Outstanding-operation counter: simultaneous issue and return cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({issue, last_v})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky flag: the multiplier strobe must track the tag pipe exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mul_valid_out != last_v) begin
      err <= 1'b1;
    end
  end

  assign o_in_flight = in_flight;
  assign o_idle      = (in_flight == '0);
  assign o_err       = err;

endmodule
`default_nettype wire

// File: tb/tb_fmul_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_fmul_share_arb
// Brief   : Self-checking bench for fmul_share_arb with a behavioural
//           three-stage multiplier and an issue-order result scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fmul_share_arb;

  localparam int N = 4;
  localparam int L = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_en;
  logic [N-1:0]     req_valid;
  logic [N-1:0][31:0] req_op_a;
  logic [N-1:0][31:0] req_op_b;
  logic [N-1:0]     req_ready;
  logic             mul_valid_in;
  logic [31:0]      mul_op_a;
  logic [31:0]      mul_op_b;
  logic             mul_valid_out;
  logic [31:0]      mul_res;
  logic             mul_ovf, mul_unf, mul_inv;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_res;
  logic [2:0]       rsp_flags;
  logic [1:0]       o_in_flight;
  logic             o_idle;
  logic             o_err;
  logic             force_vout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;
  exp_t sb[$];

  fmul_share_arb #(.N_REQ(N), .L_MUL(L)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en),
    .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_ready(req_ready), .mul_valid_in(mul_valid_in),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_valid_out(mul_valid_out), .mul_res(mul_res),
    .mul_ovf(mul_ovf), .mul_unf(mul_unf), .mul_inv(mul_inv),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .o_in_flight(o_in_flight), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Simplified FP32 multiply (truncating, denormals flushed): {flags,result}
  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {3'b001, 32'h7FC00000};
    if (ea == 0 || eb == 0)     return {3'b000, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    return {3'b000, s, e[7:0], m};
  endfunction

  // Behavioural multiplier pipe, reset by the same rst_n
  logic        m_v [L];
  logic [34:0] m_d [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < L; s++) begin
        m_v[s] <= 1'b0;
        m_d[s] <= '0;
      end
    end else begin
      m_v[0] <= mul_valid_in;
      m_d[0] <= fp_mul(mul_op_a, mul_op_b);
      for (int s = 1; s < L; s++) begin
        m_v[s] <= m_v[s-1];
        m_d[s] <= m_d[s-1];
      end
    end
  end
  assign mul_valid_out = m_v[L-1] | force_vout;
  assign mul_res       = m_d[L-1][31:0];
  assign mul_ovf       = m_d[L-1][34];
  assign mul_unf       = m_d[L-1][33];
  assign mul_inv       = m_d[L-1][32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: push on transfer, pop when the response is due
  exp_t e;
  logic [34:0] r;
  int g;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("sb_rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        chk("sb_rsp_res", rsp_res, e.res);
        chk("sb_rsp_flags", 32'(rsp_flags), 32'(e.flg));
      end else begin
        chk("sb_no_rsp", 32'(rsp_valid), 32'h0);
      end
      if (mul_valid_in) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk("grant_onehot", 32'($countones(req_ready)), 32'h1);
        chk("grant_valid", 32'(req_valid[g]), 32'h1);
        chk("mul_op_a", mul_op_a, req_op_a[g]);
        chk("mul_op_b", mul_op_b, req_op_b[g]);
        r = fp_mul(req_op_a[g], req_op_b[g]);
        sb.push_back('{due: cyc + L, idx: g, res: r[31:0], flg: r[34:32]});
      end else begin
        chk("no_issue_ready", 32'(req_ready), 32'h0);
        chk("no_issue_ops", mul_op_a | mul_op_b, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g [3];
    rst_n      = 1'b0;
    i_en       = 1'b1;
    force_vout = 1'b0;
    req_valid  = 4'hF;
    req_op_a[0] = 32'h3F800000;  // 1.0
    req_op_a[1] = 32'h40000000;  // 2.0
    req_op_a[2] = 32'h40400000;  // 3.0
    req_op_a[3] = 32'h40800000;  // 4.0
    for (int i = 0; i < N; i++) req_op_b[i] = 32'h40000000;

    // Reset state with every request already asserted
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mul_valid_in", 32'(mul_valid_in), 32'h0);
    chk("rst_in_flight", 32'(o_in_flight), 32'h0);
    chk("rst_idle", 32'(o_idle), 32'h1);
    chk("rst_err", 32'(o_err), 32'h0);

    // All four valid from reset: grants 0,1,2,3,0
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      step();
    end
    req_valid = 4'h0;
    repeat (5) step();
    @(negedge clk);
    chk("burst_idle", 32'(o_idle), 32'h1);

    // Single op on requester 0: 2.0 * 3.0 = 6.0 after three cycles
    step();
    req_op_a[0] = 32'h40000000;
    req_op_b[0] = 32'h40400000;
    req_valid   = 4'b0001;
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'h0;
    @(negedge clk);
    chk("single_in_flight", 32'(o_in_flight), 32'h1);
    step();
    step();
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_res", rsp_res, 32'h40C00000);
    chk("single_rsp_flags", 32'(rsp_flags), 32'h0);
    repeat (2) step();

    // Overflow on requester 2
    req_op_a[2] = 32'h7F000000;
    req_op_b[2] = 32'h40000000;
    req_valid   = 4'b0100;
    @(negedge clk);
    chk("ovf_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'h0;
    step();
    step();
    @(negedge clk);
    chk("ovf_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("ovf_rsp_flags", 32'(rsp_flags), 32'h4);
    repeat (2) step();

    // Three ops in flight, then enable dropped: drain 3 -> 0
    req_op_a[2] = 32'h40400000;
    req_valid   = 4'hF;
    exp_g[0] = 4'b1000;
    exp_g[1] = 4'b0001;
    exp_g[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en_grant", 32'(req_ready), 32'(exp_g[k]));
      step();
    end
    i_en = 1'b0;
    for (int k = 3; k > 0; k--) begin
      @(negedge clk);
      chk("drain_ready", 32'(req_ready), 32'h0);
      chk("drain_in_flight", 32'(o_in_flight), 32'(k));
      step();
    end
    @(negedge clk);
    chk("drain_in_flight_0", 32'(o_in_flight), 32'h0);
    chk("drain_idle", 32'(o_idle), 32'h1);

    // Reset in the middle of a burst
    step();
    i_en = 1'b1;
    @(negedge clk);
    chk("mid_grant2", 32'(req_ready), 32'h4);
    step();
    @(negedge clk);
    chk("mid_grant3", 32'(req_ready), 32'h8);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_flight", 32'(o_in_flight), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_idle", 32'(o_idle), 32'h1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    chk("post_rst_rsp0", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("post_rst_rsp1", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("post_rst_rsp2", 32'(rsp_valid), 32'h0);
    step();
    req_valid = 4'h0;
    repeat (5) step();
    @(negedge clk);
    chk("post_rst_idle", 32'(o_idle), 32'h1);
    chk("post_rst_err", 32'(o_err), 32'h0);

    // Spurious multiplier strobe with an empty tag pipe
    step();
    force_vout = 1'b1;
    step();
    force_vout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("err_sticky", 32'(o_err), 32'h1);
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("err_rst", 32'(o_err), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("err_after_rst", 32'(o_err), 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmul_share_arb.md
FMUL_SHARE_ARB -- requirements
Module: fmul_share_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one pipelined FP32 multiplier.
REQ-002 The block SHALL have parameter L_MUL, default 3, latency in cycles of the attached multiplier pipe.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port i_en  input  1  arbitration enable; 0 blocks all grants.
REQ-006 The block SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-007 The block SHALL have port req_op_a, req_op_b  input  N_REQ x 32  per-requester IEEE-754 single operands.
REQ-008 The block SHALL have port req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 The block SHALL have port mul_valid_in  output  1  issue strobe to multiplier.
REQ-010 The block SHALL have port mul_op_a, mul_op_b  output  32  granted operands to multiplier.
REQ-011 The block SHALL have port mul_valid_out  input  1  result strobe from multiplier.
REQ-012 The block SHALL have port mul_res  input  32  result, plus ports mul_ovf, mul_unf, mul_inv  input  1 each  exception flags.
REQ-013 The block SHALL have port rsp_valid  output  N_REQ  one-hot result strobe routed to the originating requester.
REQ-014 The block SHALL have port rsp_res  output  32  result, plus port rsp_flags  output  3  {ovf,unf,inv}.
REQ-015 The block SHALL have port o_in_flight  output  $clog2(L_MUL+1)  count of issued, unreturned operations.
REQ-016 The block SHALL have ports o_idle  output  1  (in_flight==0), and o_err  output  1  sticky tag/strobe mismatch.

Function
REQ-017 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, first i with req_valid[i] is granted, and req_ready SHALL be combinational from req_valid, rr_ptr and i_en.
REQ-018 On a transfer to requester g, rr_ptr SHALL become (g+1) mod N_REQ; with no transfer, rr_ptr SHALL hold.
REQ-019 At most one req_ready bit SHALL be 1 per cycle; all SHALL be 0 when i_en=0 or no req_valid is set.
REQ-020 mul_valid_in SHALL equal OR(req_ready & req_valid); mul_op_a/b SHALL be the granted operands, 0 when no grant.
REQ-021 A tag shift register of L_MUL stages SHALL carry {valid, requester index}, stage 0 loaded from the current grant and advanced every cycle.
REQ-022 When the last tag stage is valid, rsp_valid SHALL be one-hot at that index, with rsp_res=mul_res and rsp_flags={mul_ovf,mul_unf,mul_inv}; otherwise rsp_valid=0 and rsp_res/rsp_flags=0.
REQ-023 Latency: a transfer at cycle t SHALL produce rsp_valid at cycle t+L_MUL, and back-to-back transfers SHALL give one response per cycle in issue order.
REQ-024 Responses SHALL NOT be back-pressurable; the requester SHALL accept rsp_valid whenever it asserts.
REQ-025 o_in_flight SHALL increment on issue-only, decrement on return-only, and hold when both or neither occur.
REQ-026 o_err SHALL set when mul_valid_out differs from the last tag stage's valid bit, and SHALL clear only on reset.
REQ-027 Deasserting i_en SHALL stop new grants only; in-flight tags SHALL still drain and respond.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear rr_ptr, all tag stages, o_in_flight and o_err.
REQ-029 While rst_n is low and after reset: req_ready=0, mul_valid_in=0, rsp_valid=0, o_in_flight=0, o_idle=1, o_err=0.
REQ-030 Operations in flight at reset SHALL be discarded; the multiplier is reset by the same rst_n.

Structure
REQ-031 A shared package SHALL hold the FP32 width, the flag-vector typedef {ovf,unf,inv} and the default N_REQ/L_MUL values.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arbiter (req, ptr, en -> one-hot grant, index).
REQ-033 The multiplier itself SHALL stay outside the block and connect through the mul_* ports.

Verification
REQ-034 The bench SHALL cover: only req 0 with a=0x40000000, b=0x40400000 at cycle t -> rsp_valid=0001, rsp_res=0x40C00000 at t+3.
REQ-035 The bench SHALL cover: all four requesters valid continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; responses likewise from t+3.
REQ-036 The bench SHALL cover: req 2 transfers with a=0x7F000000, b=0x40000000 -> rsp_valid=0100, rsp_flags ovf=1.
REQ-037 The bench SHALL cover: i_en=0 while 3 ops in flight -> no new grants, o_in_flight 3->0 over 3 cycles, then o_idle=1.
REQ-038 The bench SHALL cover: rst_n low mid-burst -> o_in_flight=0, no rsp_valid after release, and the first grant after release goes to requester 0.
REQ-039 The bench SHALL cover: forced mul_valid_out=1 with an empty tag -> o_err=1, held until reset.
